// File: rtl/accl_pair_sequencer_pkg.sv
// Shared types and sizing for the getAccl pair sequencer.
// Tags travel alongside getAccl; results carry the tag into the output buffer.
package nbody_pkg;

    localparam int MAX_BODIES_DEFAULT = 64;
    localparam int IDX_W              = $clog2(MAX_BODIES_DEFAULT);
    // Matches the getAccl stage chain: 1 + 20 + 11 + 20 + 27 + 4*11
    localparam int ACCL_LAT_DEFAULT   = 1 + 20 + 11 + 20 + 27 + 4 * 11;
    localparam int FIFO_DEPTH_DEFAULT = 256;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_ISSUE,
        SEQ_DRAIN,
        SEQ_DONE
    } seq_state_e;

    typedef struct packed {
        logic             v;
        logic [IDX_W-1:0] i;
        logic [IDX_W-1:0] j;
        logic             last_j;
        logic             last;
    } accl_tag_t;

    typedef struct packed {
        logic [63:0]      ax;
        logic [63:0]      ay;
        logic [IDX_W-1:0] i;
        logic [IDX_W-1:0] j;
        logic             last_j;
        logic             last;
    } accl_res_t;

endpackage

// File: rtl/accl_pair_sequencer_if.sv
// Result stream from the pair sequencer to the per-body accumulator.
// Plain valid/ready; payload is stable while valid is held without ready.
interface accl_pair_sequencer_if;
    import nbody_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_ax;
    logic [63:0]      out_ay;
    logic [IDX_W-1:0] out_i;
    logic [IDX_W-1:0] out_j;
    logic             out_last_j;
    logic             out_last;

    modport master (
        output out_valid, out_ax, out_ay, out_i, out_j, out_last_j, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_ax, out_ay, out_i, out_j, out_last_j, out_last,
        output out_ready
    );

endinterface

// File: rtl/accl_pair_sequencer_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; any DEPTH >= 2.
// Head entry is presented combinationally while not empty.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: storage has no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);

endmodule

// File: rtl/accl_pair_sequencer.sv
// Streams every ordered body pair (i,j) into getAccl, tracks each with a tag
// pipe matched to its latency, and buffers tagged results for the accumulator.
module accl_pair_sequencer
    import nbody_pkg::*;
#(
    parameter int MAX_BODIES = MAX_BODIES_DEFAULT,
    parameter int ACCL_LAT   = ACCL_LAT_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W:0]   n_bodies,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] rd_addr_i,
    output logic [IDX_W-1:0] rd_addr_j,
    input  logic [63:0]      rd_x_i,
    input  logic [63:0]      rd_y_i,
    input  logic [63:0]      rd_x_j,
    input  logic [63:0]      rd_y_j,
    input  logic [63:0]      rd_m_j,
    output logic [63:0]      accl_x1,
    output logic [63:0]      accl_y1,
    output logic [63:0]      accl_x2,
    output logic [63:0]      accl_y2,
    output logic [63:0]      accl_m2,
    input  logic [63:0]      accl_ax,
    input  logic [63:0]      accl_ay,
    accl_pair_sequencer_if.master res
);

    // One extra stage covers the RAM read between address and getAccl input.
    localparam int             PIPE_D    = ACCL_LAT + 1;
    localparam int             CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [IDX_W:0] N_MAX     = (IDX_W + 1)'(MAX_BODIES);
    localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

    seq_state_e       state, state_nxt;
    logic [IDX_W:0]   n_q, n_m1, n_clamped;
    logic [IDX_W-1:0] i_q, j_q;
    logic [CNT_W-1:0] inflight, fifo_count;
    logic [CNT_W:0]   total;
    logic             accept, issue, credit, pop, row_end, sweep_end, fifo_empty;
    accl_tag_t        pipe [PIPE_D];
    accl_tag_t        tag_in, tag_out;
    accl_res_t        wr_res, head;

    assign n_clamped = (n_bodies > N_MAX) ? N_MAX : n_bodies;
    assign n_m1      = n_q - 1'b1;
    assign row_end   = ({1'b0, j_q} == n_m1);
    assign sweep_end = row_end && ({1'b0, i_q} == n_m1);
    assign total     = {1'b0, fifo_count} + {1'b0, inflight};
    assign credit    = (total < DEPTH_LIM);
    assign accept    = start && (state == SEQ_IDLE) && !busy;
    assign issue     = (state == SEQ_ISSUE) && credit;
    assign pop       = res.out_valid && res.out_ready;
    assign tag_out   = pipe[PIPE_D-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= SEQ_IDLE;
        else      state <= state_nxt;
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        tag_in    = '0;
        if (issue) tag_in = '{v: 1'b1, i: i_q, j: j_q, last_j: row_end, last: sweep_end};
        unique case (state)
            SEQ_IDLE:  if (accept) state_nxt = (n_clamped == '0) ? SEQ_DONE : SEQ_ISSUE;
            SEQ_ISSUE: if (issue && sweep_end) state_nxt = SEQ_DRAIN;
            SEQ_DRAIN: if (pop && res.out_last) state_nxt = SEQ_DONE;
            SEQ_DONE:  state_nxt = SEQ_IDLE;
            default:   state_nxt = SEQ_IDLE;
        endcase
    end

    // NOTE: all clocked state uses non-blocking assignment to avoid ordering races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_q <= '0;
            i_q <= '0;
            j_q <= '0;
        end else if (accept) begin
            n_q <= n_clamped;
            i_q <= '0;
            j_q <= '0;
        end else if (issue) begin
            if (sweep_end) begin
                i_q <= '0;
                j_q <= '0;
            end else if (row_end) begin
                i_q <= i_q + 1'b1;
                j_q <= '0;
            end else begin
                j_q <= j_q + 1'b1;
            end
        end
    end

    // Busy spans the accepted start through the done pulse, so a start seen
    // in the done cycle cannot re-arm the sequencer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= (state == SEQ_DONE);
            if (accept)    busy <= 1'b1;
            else if (done) busy <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < PIPE_D; k++) pipe[k] <= '0;
            inflight <= '0;
        end else begin
            pipe[0] <= tag_in;
            for (int k = 1; k < PIPE_D; k++) pipe[k] <= pipe[k-1];
            inflight <= inflight + CNT_W'(issue) - CNT_W'(tag_out.v);
        end
    end

    assign rd_addr_i = i_q;
    assign rd_addr_j = j_q;
    assign accl_x1   = rd_x_i;
    assign accl_y1   = rd_y_i;
    assign accl_x2   = rd_x_j;
    assign accl_y2   = rd_y_j;
    assign accl_m2   = rd_m_j;

    assign wr_res = '{ax: accl_ax, ay: accl_ay, i: tag_out.i, j: tag_out.j,
                      last_j: tag_out.last_j, last: tag_out.last};

    sync_fifo #(
        .WIDTH ($bits(accl_res_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tag_out.v),
        .wr_data (wr_res),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign res.out_valid  = !fifo_empty;
    assign res.out_ax     = head.ax;
    assign res.out_ay     = head.ay;
    assign res.out_i      = head.i;
    assign res.out_j      = head.j;
    assign res.out_last_j = head.last_j;
    assign res.out_last   = head.last;

    a_credit: assert property (@(posedge clk) disable iff (!rst) total <= DEPTH_LIM);

endmodule

// File: tb/tb_accl_pair_sequencer.sv
// Bench for accl_pair_sequencer: sync body RAM model, getAccl modelled as a
// fixed-latency delay of a reference force function, result scoreboard.
module tb_accl_pair_sequencer;
    import nbody_pkg::*;

    localparam int L     = ACCL_LAT_DEFAULT;
    localparam int DEPTH = L + 2;
    localparam int NB    = MAX_BODIES_DEFAULT;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [IDX_W:0]   n_bodies = '0;
    logic             busy, done;
    logic [IDX_W-1:0] rd_addr_i, rd_addr_j;
    logic [63:0]      rd_x_i, rd_y_i, rd_x_j, rd_y_j, rd_m_j;
    logic [63:0]      accl_x1, accl_y1, accl_x2, accl_y2, accl_m2, accl_ax, accl_ay;

    accl_pair_sequencer_if res_if ();

    accl_pair_sequencer #(
        .MAX_BODIES (NB),
        .ACCL_LAT   (L),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_bodies  (n_bodies),
        .busy      (busy),
        .done      (done),
        .rd_addr_i (rd_addr_i),
        .rd_addr_j (rd_addr_j),
        .rd_x_i    (rd_x_i),
        .rd_y_i    (rd_y_i),
        .rd_x_j    (rd_x_j),
        .rd_y_j    (rd_y_j),
        .rd_m_j    (rd_m_j),
        .accl_x1   (accl_x1),
        .accl_y1   (accl_y1),
        .accl_x2   (accl_x2),
        .accl_y2   (accl_y2),
        .accl_m2   (accl_m2),
        .accl_ax   (accl_ax),
        .accl_ay   (accl_ay),
        .res       (res_if)
    );

    always #5 clk = ~clk;

    // Reference getAccl: a = m2 * d / |d|^3, zero for coincident bodies.
    function automatic logic [127:0] ref_accl(input logic [63:0] x1, y1, x2, y2, m2);
        real dx, dy, r2, s;
        dx = $bitstoreal(x2) - $bitstoreal(x1);
        dy = $bitstoreal(y2) - $bitstoreal(y1);
        r2 = dx * dx + dy * dy;
        if (r2 == 0.0) return '0;
        s = $bitstoreal(m2) / (r2 * $sqrt(r2));
        return {$realtobits(s * dx), $realtobits(s * dy)};
    endfunction

    logic [63:0]  mem_x [NB];
    logic [63:0]  mem_y [NB];
    logic [63:0]  mem_m [NB];
    logic [127:0] dl [L];

    always @(posedge clk) begin
        rd_x_i <= mem_x[rd_addr_i];
        rd_y_i <= mem_y[rd_addr_i];
        rd_x_j <= mem_x[rd_addr_j];
        rd_y_j <= mem_y[rd_addr_j];
        rd_m_j <= mem_m[rd_addr_j];
    end

    always @(posedge clk) begin
        dl[0] <= ref_accl(accl_x1, accl_y1, accl_x2, accl_y2, accl_m2);
        for (int k = 1; k < L; k++) dl[k] <= dl[k-1];
    end

    assign accl_ax = dl[L-1][127:64];
    assign accl_ay = dl[L-1][63:0];

    typedef struct {
        logic [63:0] ax;
        logic [63:0] ay;
        int          i;
        int          j;
        bit          last_j;
        bit          last;
    } cap_t;

    cap_t cap_q [$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   valid_seen = 0;
    int   viol = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (done) done_cnt++;
            if (res_if.out_valid) valid_seen++;
            if (int'(dut.fifo_count) + int'(dut.inflight) > DEPTH) viol++;
            if (res_if.out_valid && res_if.out_ready)
                cap_q.push_back('{ax: res_if.out_ax, ay: res_if.out_ay,
                                  i: int'(res_if.out_i), j: int'(res_if.out_j),
                                  last_j: res_if.out_last_j, last: res_if.out_last});
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input logic [IDX_W:0] n);
        @(posedge clk); #1;
        n_bodies = n;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd, input string name);
        int  base;
        bit  seen;
        base = done_cnt;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (rnd) res_if.out_ready = 1'($urandom_range(0, 1));
            if (done_cnt != base) begin
                seen = 1'b1;
                break;
            end
        end
        res_if.out_ready = 1'b1;
        check({name, " done seen"}, 64'(seen), 64'd1);
    endtask

    task automatic verify_sweep(input int n, input string name);
        int           bad, ei, ej;
        logic [127:0] e;
        check({name, " count"}, 64'(cap_q.size()), 64'(n * n));
        bad = 0;
        for (int k = 0; k < cap_q.size() && k < n * n; k++) begin
            ei = k / n;
            ej = k % n;
            e  = ref_accl(mem_x[ei], mem_y[ei], mem_x[ej], mem_y[ej], mem_m[ej]);
            if (cap_q[k].i != ei || cap_q[k].j != ej ||
                cap_q[k].last_j != (ej == n - 1) || cap_q[k].last != (k == n * n - 1) ||
                cap_q[k].ax !== e[127:64] || cap_q[k].ay !== e[63:0]) bad++;
        end
        check({name, " bad entries"}, 64'(bad), 64'd0);
    endtask

    typedef struct {
        int          i;
        int          j;
        bit          last_j;
        bit          last;
        logic [63:0] ax;
        logic [63:0] ay;
    } exp_t;

    typedef struct {
        logic [IDX_W:0] n_in;
        int             n_eff;
        bit             rnd;
    } sweep_t;

    exp_t   t1 [4];
    sweep_t sw [4];
    logic [4:0] dpat, bpat;
    logic [63:0] act_idx, exp_idx;

    initial begin
        t1[0] = '{0, 0, 1'b0, 1'b0, 64'h0, 64'h0};
        t1[1] = '{0, 1, 1'b1, 1'b0, 64'h3FF0_0000_0000_0000, 64'h0};
        t1[2] = '{1, 0, 1'b0, 1'b0, 64'hBFF0_0000_0000_0000, 64'h0};
        t1[3] = '{1, 1, 1'b1, 1'b1, 64'h0, 64'h0};
        sw[0] = '{7'd1,   1,  1'b0};
        sw[1] = '{7'd5,   5,  1'b1};
        sw[2] = '{7'd127, NB, 1'b0};
        sw[3] = '{7'd64,  NB, 1'b1};

        mem_x[0] = $realtobits(0.0); mem_y[0] = $realtobits(0.0); mem_m[0] = $realtobits(1.0);
        mem_x[1] = $realtobits(1.0); mem_y[1] = $realtobits(0.0); mem_m[1] = $realtobits(1.0);
        for (int k = 2; k < NB; k++) begin
            mem_x[k] = $realtobits(real'(k % 9) * 1.25 - 3.0);
            mem_y[k] = $realtobits(real'(k / 9) * 0.5 + 2.0);
            mem_m[k] = $realtobits(0.5 + real'(k) * 0.125);
        end
        res_if.out_ready = 1'b1;

        // Reset state
        @(negedge clk); @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset out_valid", 64'(res_if.out_valid), 64'd0);
        check("reset rd_addr_i", 64'(rd_addr_i), 64'd0);
        check("reset rd_addr_j", 64'(rd_addr_j), 64'd0);
        @(posedge clk); #1 rst = 1'b1;

        // Basic order, n=2
        cap_q.delete();
        done_cnt = 0;
        pulse_start(7'd2);
        wait_done(1000, 1'b0, "t1");
        for (int k = 0; k < 4; k++) begin
            act_idx = 64'(cap_q[k].i) * 256 + 64'(cap_q[k].j) * 4 +
                      64'(cap_q[k].last_j) * 2 + 64'(cap_q[k].last);
            exp_idx = 64'(t1[k].i) * 256 + 64'(t1[k].j) * 4 +
                      64'(t1[k].last_j) * 2 + 64'(t1[k].last);
            check($sformatf("t1[%0d] idx/flags", k), act_idx, exp_idx);
            check($sformatf("t1[%0d] ax", k), cap_q[k].ax, t1[k].ax);
            check($sformatf("t1[%0d] ay", k), cap_q[k].ay, t1[k].ay);
        end
        check("t1 count", 64'(cap_q.size()), 64'd4);
        repeat (3) @(posedge clk);
        check("t1 done pulses", 64'(done_cnt), 64'd1);
        check("t1 busy after done", 64'(busy), 64'd0);

        // n=0 with start held through the done cycle
        done_cnt   = 0;
        valid_seen = 0;
        @(posedge clk); #1;
        n_bodies = '0;
        start    = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 3) start = 1'b0;
            @(negedge clk);
            dpat[k-1] = done;
            bpat[k-1] = busy;
        end
        check("n0 done pattern", 64'(dpat), 64'(5'b00010));
        check("n0 busy pattern", 64'(bpat), 64'(5'b00011));
        check("n0 done count", 64'(done_cnt), 64'd1);
        check("n0 no out_valid", 64'(valid_seen), 64'd0);

        // Backpressure: buffer fills to the credit limit, then drains in order
        cap_q.delete();
        res_if.out_ready = 1'b0;
        pulse_start(7'd16);
        repeat (400) @(posedge clk);
        @(negedge clk);
        check("bp fifo full at credit", 64'(dut.fifo_count), 64'(DEPTH));
        check("bp nothing inflight", 64'(dut.inflight), 64'd0);
        check("bp busy", 64'(busy), 64'd1);
        @(posedge clk); #1 res_if.out_ready = 1'b1;
        wait_done(3000, 1'b0, "bp");
        verify_sweep(16, "bp");

        // Start while busy is ignored
        cap_q.delete();
        done_cnt = 0;
        pulse_start(7'd3);
        repeat (20) @(posedge clk);
        pulse_start(7'd5);
        wait_done(1000, 1'b0, "busy start");
        verify_sweep(3, "busy start");
        repeat (3) @(posedge clk);
        check("busy start done pulses", 64'(done_cnt), 64'd1);

        // Reset mid-run drops everything in flight
        pulse_start(7'd16);
        repeat (50) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        cap_q.delete();
        valid_seen = 0;
        repeat (300) @(posedge clk);
        check("rst stale out_valid", 64'(valid_seen), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        pulse_start(7'd2);
        wait_done(1000, 1'b0, "rst resweep");
        verify_sweep(2, "rst resweep");

        // Table of sweeps, including clamp and full size with random ready
        for (int s = 0; s < 4; s++) begin
            cap_q.delete();
            pulse_start(sw[s].n_in);
            wait_done(sw[s].n_eff * sw[s].n_eff * 4 + 1000, sw[s].rnd, $sformatf("sweep%0d", s));
            verify_sweep(sw[s].n_eff, $sformatf("sweep%0d", s));
        end
        check("credit invariant violations", 64'(viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
